// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its return stack.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BR,
    PC_CALL,
    PC_RET
  } pc_op_t;

  localparam int unsigned PC_RESET_ADDR_DEFAULT = 0;

  // Bit positions inside the sticky error vector.
  localparam int ERR_W       = 2;
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UNF_BIT = 1;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO indexed by its occupancy count; the top entry is read combinationally.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_rd [DEPTH];
  logic [AW-1:0] top_idx;
  logic          do_push, do_pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    do_push = push && !pop && !full;
    count_d = count_q;
    if (do_pop) begin
      count_d = count_q - CW'(1);
    end else if (do_push) begin
      count_d = count_q + CW'(1);
    end
    // DEPTH is a power of two, so the low count bits minus one wrap onto the top slot.
    top_idx = count_q[AW-1:0] - AW'(1);
    top     = mem_rd[top_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_q <= '0;
      end else if (do_push && (count_q[AW-1:0] == AW'(gi))) begin
        entry_q <= din;
      end
    end

    assign mem_rd[gi] = entry_q;
  end

endmodule

// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with return-address stack and sticky overflow/underflow flags.
// Define PC_STACK_SEQ_REL_BRANCH_EN for PC-relative branch/call targets (default: absolute).
module pc_stack_seq
  import pc_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = PC_RESET_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              brnch_yes,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] addr,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_unf
);

  pc_op_t            op;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ret_addr, br_target, stk_top;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              stk_push, stk_pop;

  assign ret_addr = addr_q + ADDR_W'(1);

`ifdef PC_STACK_SEQ_REL_BRANCH_EN
  // Two's-complement offset; the modulo sum makes negative offsets fall out naturally.
  assign br_target = addr_q + target;
`else
  assign br_target = target;
`endif

  always_comb begin
    op = PC_HOLD;
    if (en) begin
      if (ret) begin
        op = PC_RET;
      end else if (call) begin
        op = PC_CALL;
      end else if (brnch_yes) begin
        op = PC_BR;
      end else begin
        op = PC_INC;
      end
    end
  end

  always_comb begin
    addr_d   = addr_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    // A new error in the same cycle overrides the clear.
    err_d    = err_clr ? '0 : err_q;
    case (op)
      PC_INC: addr_d = ret_addr;
      PC_BR:  addr_d = br_target;
      PC_CALL: begin
        if (stk_full) begin
          err_d[ERR_OVF_BIT] = 1'b1;
        end else begin
          stk_push = 1'b1;
          addr_d   = br_target;
        end
      end
      PC_RET: begin
        if (stk_empty) begin
          err_d[ERR_UNF_BIT] = 1'b1;
        end else begin
          stk_pop = 1'b1;
          addr_d  = stk_top;
        end
      end
      PC_HOLD: addr_d = addr_q;
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= ADDR_W'(RESET_ADDR);
      err_q  <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  pc_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (ret_addr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign addr    = addr_q;
  assign stk_ovf = err_q[ERR_OVF_BIT];
  assign stk_unf = err_q[ERR_UNF_BIT];

endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed, table-driven bench for pc_stack_seq (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0).
module tb_pc_stack_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, brnch_yes, call, ret, err_clr;
  logic [7:0] target;
  logic [7:0] addr;
  logic       stk_full, stk_empty, stk_ovf, stk_unf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en, br, call, ret, clr;
    logic [7:0] tgt;
    logic [7:0] exp_addr;
    logic       exp_full, exp_empty, exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[$];

  pc_stack_seq #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .brnch_yes (brnch_yes),
    .call      (call),
    .ret       (ret),
    .target    (target),
    .err_clr   (err_clr),
    .addr      (addr),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] a, input logic f, input logic e,
                         input logic o, input logic u);
    chk({tag, ".addr"},  32'(addr),      32'(a));
    chk({tag, ".full"},  32'(stk_full),  32'(f));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(e));
    chk({tag, ".ovf"},   32'(stk_ovf),   32'(o));
    chk({tag, ".unf"},   32'(stk_unf),   32'(u));
  endtask

  task automatic drive(input logic e, input logic b, input logic c, input logic r,
                       input logic cl, input logic [7:0] t);
    en = e; brnch_yes = b; call = c; ret = r; err_clr = cl; target = t;
  endtask

  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0, 8'h00);
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic void add(input logic e, input logic b, input logic c, input logic r,
                              input logic cl, input logic [7:0] t, input logic [7:0] a,
                              input logic f, input logic em, input logic o, input logic u);
    vec_t v;
    v = '{e, b, c, r, cl, t, a, f, em, o, u};
    vecs.push_back(v);
  endfunction

  initial begin
`ifdef PC_STACK_SEQ_REL_BRANCH_EN
    add(1,1,0,0,0, 8'h05, 8'h05, 0,1,0,0);
    add(1,1,0,0,0, 8'hFB, 8'h00, 0,1,0,0);
    add(1,1,0,0,0, 8'hFE, 8'hFE, 0,1,0,0);
    add(1,1,0,0,0, 8'h04, 8'h02, 0,1,0,0);
    add(1,0,1,0,0, 8'h10, 8'h12, 0,0,0,0);
    add(1,0,0,1,0, 8'h00, 8'h03, 0,1,0,0);
    add(1,0,0,0,0, 8'h00, 8'h04, 0,1,0,0);
`else
    add(1,1,0,0,0, 8'h10, 8'h10, 0,1,0,0);
    add(1,0,1,0,0, 8'h40, 8'h40, 0,0,0,0);
    add(1,0,0,0,0, 8'h00, 8'h41, 0,0,0,0);
    add(1,0,0,0,0, 8'h00, 8'h42, 0,0,0,0);
    add(1,0,0,1,0, 8'h00, 8'h11, 0,1,0,0);
    add(0,0,1,0,0, 8'h99, 8'h11, 0,1,0,0);
    add(1,0,1,0,0, 8'h20, 8'h20, 0,0,0,0);
    add(1,0,1,0,0, 8'h30, 8'h30, 0,0,0,0);
    add(1,0,1,0,0, 8'h50, 8'h50, 0,0,0,0);
    add(1,0,1,0,0, 8'h60, 8'h60, 1,0,0,0);
    add(1,0,1,0,0, 8'h70, 8'h60, 1,0,1,0);
    add(1,0,0,1,0, 8'h00, 8'h51, 0,0,1,0);
    add(1,0,0,1,0, 8'h00, 8'h31, 0,0,1,0);
    add(1,0,0,1,0, 8'h00, 8'h21, 0,0,1,0);
    add(1,0,0,1,0, 8'h00, 8'h12, 0,1,1,0);
    add(1,0,0,1,0, 8'h00, 8'h12, 0,1,1,1);
    add(1,0,0,0,1, 8'h00, 8'h13, 0,1,0,0);
    add(1,0,0,1,1, 8'h00, 8'h13, 0,1,0,1);
    add(0,0,0,0,1, 8'h00, 8'h13, 0,1,0,0);
    add(0,0,0,1,0, 8'h00, 8'h13, 0,1,0,0);
    add(1,0,1,0,0, 8'h80, 8'h80, 0,0,0,0);
    add(1,0,1,1,0, 8'h90, 8'h14, 0,1,0,0);
    add(1,0,1,1,0, 8'h90, 8'h14, 0,1,0,1);
    add(1,1,0,0,0, 8'hFF, 8'hFF, 0,1,0,1);
    add(1,0,0,0,0, 8'h00, 8'h00, 0,1,0,1);
    add(1,0,1,0,0, 8'h05, 8'h05, 0,0,0,1);
    add(1,0,0,1,0, 8'h00, 8'h01, 0,1,0,1);
    add(1,1,1,0,0, 8'h33, 8'h33, 0,0,0,1);
    add(1,0,0,1,0, 8'h00, 8'h02, 0,1,0,1);
`endif

    // Reset state, observed while rst is still high and without a clock edge.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00);
    #3;
    chk_all("reset", 8'h00, 0, 1, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Free-running increment wraps from 0xFF to 0x00 with no gaps.
    drive(1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 chk("inc_run", 32'(addr), 32'((i + 1) % 256));
    end
    $display("inc run: 300 cycles, final addr=0x%0h", addr);

    reset_pulse();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].br, vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_full, vecs[i].exp_empty,
              vecs[i].exp_ovf, vecs[i].exp_unf);
      $display("vec %0d: en=%0b br=%0b call=%0b ret=%0b clr=%0b tgt=0x%0h -> addr=0x%0h full=%0b empty=%0b ovf=%0b unf=%0b",
               i, vecs[i].en, vecs[i].br, vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].tgt,
               addr, stk_full, stk_empty, stk_ovf, stk_unf);
    end

    // Asynchronous reset mid-CALL with two entries stacked and an error pending.
    reset_pulse();
    drive(1, 0, 0, 1, 0, 8'h00);
    @(posedge clk);
    #1 chk("arst.unf_set", 32'(stk_unf), 32'd1);
    drive(1, 0, 1, 0, 0, 8'h20);
    @(posedge clk);
    #1 chk("arst.addr1", 32'(addr), 32'h20);
    drive(1, 0, 1, 0, 0, 8'h30);
    @(posedge clk);
    #1 chk("arst.empty2", 32'(stk_empty), 32'd0);
    chk("arst.full2", 32'(stk_full), 32'd0);
    drive(1, 0, 1, 0, 0, 8'h60);
    #3 rst = 1'b1;
    #1 chk_all("arst.now", 8'h00, 0, 1, 0, 0);
    @(posedge clk);
    #1 chk_all("arst.held", 8'h00, 0, 1, 0, 0);
    $display("async reset mid-call: addr=0x%0h empty=%0b ovf=%0b unf=%0b", addr, stk_empty, stk_ovf, stk_unf);

    // Release with a CALL presented: first edge performs it from the reset state.
    drive(1, 0, 1, 0, 0, 8'h40);
    rst = 1'b0;
    @(posedge clk);
    #1 chk_all("rel.call", 8'h40, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 8'h77);
    @(posedge clk);
    #1 chk_all("rel.callret", 8'h01, 0, 1, 0, 0);
    $display("release then call+ret: addr=0x%0h empty=%0b", addr, stk_empty);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack_seq.md
# pc_stack_seq

Parametrised program-counter sequencer with a hardware return-address stack, the next generation of the 8-bit computer's `PC` block. It holds the fetch address and supplies it to the memory address mux and the ALU. Each cycle it increments, branches, calls or returns. Call/return use an internal LIFO of configurable depth, with full/empty flags and sticky overflow/underflow errors.

## Interface
- `ADDR_W`, default 8: address width; all address arithmetic is modulo 2^ADDR_W.
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥ 2 and a power of two.
- `RESET_ADDR`, default 0: value loaded into `addr` by reset.

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: advance enable; when low, all state holds.
- `brnch_yes`, input, 1: take branch to `target` this cycle.
- `call`, input, 1: push return address, then jump to `target`.
- `ret`, input, 1: pop the stack into `addr`.
- `target`, input, ADDR_W: branch/call destination (`regBuf` equivalent).
- `err_clr`, input, 1: synchronous clear of the sticky error bits.
- `addr`, output, ADDR_W: current fetch address, registered.
- `stk_full`, output, 1: stack count == STACK_DEPTH.
- `stk_empty`, output, 1: stack count == 0.
- `stk_ovf`, output, 1: sticky; a call was attempted while the stack was full.
- `stk_unf`, output, 1: sticky; a ret was attempted while the stack was empty.

## Operation
- Reset values: `addr` = RESET_ADDR, stack count = 0, all stack entries = 0, `stk_ovf` = `stk_unf` = 0, `stk_empty` = 1, `stk_full` = 0.
- Operation select, evaluated when `en` = 1, highest priority first:
  1. `ret`
  2. `call`
  3. `brnch_yes`
  4. increment
- When `en` = 0, everything holds except `err_clr`, which is honoured regardless of `en`.
- INC: `addr` ← `addr` + 1. The increment wraps from 2^ADDR_W−1 to 0.
- BR: `addr` ← branch target (see Configuration). Stack is untouched.
- CALL, stack not full: push `addr` + 1 (mod 2^ADDR_W), then `addr` ← branch target, count + 1.
- CALL, stack full: `addr` holds, there is no push, and `stk_ovf` ← 1.
- RET, stack not empty: `addr` ← top entry, count − 1.
- RET, stack empty: `addr` holds and `stk_unf` ← 1.
- `ret` and `call` asserted together: RET wins and `call` is ignored. This is not an error.
- `err_clr` and a new error in the same cycle: the new error wins, so the bit reads 1 afterwards.
- The stack is a LIFO indexed by count. Entries above count are don't-care and are not cleared on pop.

## Timing
- All state updates on the rising `clk` edge. `rst` acts immediately, without waiting for a clock edge.
- `addr` is valid one cycle after the operation is sampled. Latency is 1 cycle for every operation. There are no bubbles.
- `stk_full` and `stk_empty` are combinational from the registered count. They reflect the state after the last edge.
- Sticky bits are registered and assert in the cycle after the offending edge.
- Back-to-back CALL/RET every cycle is supported at full rate.
- Reset released mid-sequence: the first edge after deassertion performs the operation then presented, starting from the reset state.

## Configuration
- Macro: `PC_STACK_SEQ_REL_BRANCH_EN`.
- Defined: the branch target is `addr` + `target`, with `target` treated as two's-complement and the sum taken modulo 2^ADDR_W. This applies to both BR and CALL.
- Undefined: the branch target is `target` itself (absolute). This is the legacy `PC` behaviour.
- The return address is always `addr` + 1, in both modes.

## Structure
- Shared package `pc_pkg` holds:
  - enum `pc_op_t` with values PC_HOLD, PC_INC, PC_BR, PC_CALL, PC_RET;
  - the constant for the default RESET_ADDR;
  - the index positions of the error bits.
- Sub-module `pc_ret_stack` implements the LIFO storage:
  - parameters DEPTH and W;
  - ports push, pop, din, top, full, empty;
  - the same `clk`/`rst`.
- The top level contains the priority decode, the next-address mux and the sticky error logic.

## Test plan
- Reset, then hold `en` = 1 with no other inputs for 300 cycles (ADDR_W = 8) → `addr` counts 0, 1, …, 255, 0, … with no gaps.
- At `addr` = 0x10, assert `call` with `target` = 0x40 (absolute mode) → next `addr` = 0x40, `stk_empty` = 0. Increment to 0x42, then assert `ret` → `addr` = 0x11.
- From an empty stack, perform 5 CALLs with STACK_DEPTH = 4 → `stk_full` = 1 after the 4th; the 5th holds `addr` and sets `stk_ovf` = 1. Then 4 RETs return the addresses in LIFO order and `stk_empty` = 1.
- Assert `ret` on an empty stack → `addr` unchanged and `stk_unf` = 1. Then `err_clr` → `stk_unf` = 0 on the next cycle.
- With `PC_STACK_SEQ_REL_BRANCH_EN` defined, `addr` = 0x05 and `brnch_yes` with `target` = 0xFB (−5) → `addr` = 0x00. Then `addr` = 0xFE with `target` = 0x04 → `addr` = 0x02 (wraps).
- Assert `rst` asynchronously mid-CALL, with count = 2 → `addr` = RESET_ADDR, `stk_empty` = 1 and both errors 0, all immediately without a clock edge. Also check `call` and `ret` asserted together → the pop is taken.
